// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch unit bus bundle covering PC control, instruction memory and decode handshake.
interface fetch_unit_if #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32
);
   logic [PC_WIDTH-1:0]    PC;
   logic                   PCsrc;
   logic                   pc_adv;
   logic                   mem_req;
   logic [PC_WIDTH-1:0]    mem_addr;
   logic                   mem_valid;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    instr_pc;
   modport master (
      input  PC, PCsrc, mem_valid, mem_rdata, instr_ready,
      output pc_adv, mem_req, mem_addr, instr_valid, instr, instr_pc
   );
   modport slave (
      output PC, PCsrc, mem_valid, mem_rdata, instr_ready,
      input  pc_adv, mem_req, mem_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry FIFO, flushed on redirect.
module fetch_unit #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 2
) (
   input logic         clk,
   input logic         rst,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;
   state_t                             state;
   logic [PC_WIDTH-1:0]                req_pc;
   logic [AW-1:0]                      wr_ptr, rd_ptr;
   logic [CW-1:0]                      count;
   logic [PC_WIDTH+INSTR_WIDTH-1:0]    fifo [DEPTH];
   logic                               issue, push, pop;
   always_comb begin
      issue = state == REQ && !bus.PCsrc && count != CW'(DEPTH);
      push  = state == WAIT && bus.mem_valid && !bus.PCsrc;
      pop   = bus.instr_valid && bus.instr_ready;
   end
   assign bus.mem_req     = issue;
   assign bus.mem_addr    = issue ? bus.PC : '0;
   assign bus.pc_adv      = push;
   assign bus.instr_valid = count != '0;
   // Head is gated so stale storage never leaks out while the buffer is empty
   assign {bus.instr_pc, bus.instr} = bus.instr_valid ? fifo[rd_ptr] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         req_pc <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // A response ends WAIT/DISCARD either way; redirect during WAIT still owes one response
         state <= state == IDLE ? REQ :
                  state == REQ ? (issue ? WAIT : REQ) :
                  bus.mem_valid ? REQ :
                  (state == WAIT && bus.PCsrc) ? DISCARD : state;
         if (issue) req_pc <= bus.PC;
         if (bus.PCsrc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= {req_pc, bus.mem_rdata};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked against a queue-based model of the fetch contract.
module tb_fetch_unit;
   localparam int PW = 16, IW = 32, D = 2;
   logic clk = 0, rst;
   always #5 clk = ~clk;
   fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus();
   fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed { logic [PW-1:0] pc; logic [IW-1:0] w; } ent_t;
   ent_t          q[$];
   int            total = 0, bad = 0;
   logic [PW-1:0] pc_reg, pend_addr, last_req;
   bit            pend, stale;
   int            cnt, lat_max, reqs, pops;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] word(input logic [PW-1:0] a);
      return {a ^ 16'hA5C3, ~a};
   endfunction

   // One clock: drive at negedge, compare #1 later, then advance the model to the next edge
   task automatic cycle(input bit ready, input bit redir, input logic [PW-1:0] tgt);
      bit mv, adv;
      @(negedge clk);
      if (pend) cnt--;
      mv = pend && cnt == 0;
      bus.mem_valid   = mv;
      bus.mem_rdata   = mv ? word(pend_addr) : '0;
      bus.instr_ready = ready;
      bus.PCsrc       = redir;
      bus.PC          = pc_reg;
      #1;
      check("instr_valid", bus.instr_valid, q.size() != 0);
      if (q.size() != 0) begin
         check("instr_pc", bus.instr_pc, q[0].pc);
         check("instr", bus.instr, q[0].w);
      end
      adv = mv && !stale && !redir;
      check("pc_adv", bus.pc_adv, adv);
      if (bus.mem_req) begin
         check("req_outstanding", pend, 0);
         check("req_on_redirect", redir, 0);
         check("req_room", q.size() < D, 1);
         check("mem_addr", bus.mem_addr, pc_reg);
      end else check("mem_addr_idle", bus.mem_addr, 0);
      if (q.size() != 0 && ready) begin
         void'(q.pop_front());
         pops++;
      end
      if (adv) q.push_back({pend_addr, word(pend_addr)});
      if (mv) pend = 0;
      if (bus.mem_req) begin
         pend = 1;
         stale = 0;
         pend_addr = bus.mem_addr;
         last_req = bus.mem_addr;
         cnt = $urandom_range(lat_max, 1);
         reqs++;
      end
      if (redir) begin
         q.delete();
         stale = 1;
         pc_reg = tgt;
      end else if (adv) pc_reg = pc_reg + 16'd4;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      bus.mem_valid = 0;
      bus.PCsrc = 0;
      bus.PC = '0;
      @(negedge clk);
      rst = 0;
      q.delete();
      pend = 0;
      stale = 0;
      pc_reg = '0;
   endtask

   initial begin
      int r0;
      rst = 1;
      bus.PC = '0; bus.PCsrc = 0; bus.mem_valid = 0; bus.mem_rdata = '0; bus.instr_ready = 0;
      pc_reg = '0; pend = 0; stale = 0; cnt = 0; reqs = 0; pops = 0; lat_max = 1; last_req = '0;
      #12;
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_pc_adv", bus.pc_adv, 0);
      check("rst_instr_valid", bus.instr_valid, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_instr_pc", bus.instr_pc, 0);
      do_reset();

      // streaming with single-cycle memory and decode always ready
      repeat (30) cycle(1, 0, '0);
      check("stream_progress", pops >= 10, 1);

      // backpressure: exactly DEPTH fetches then stall, then drain in order
      do_reset();
      reqs = 0;
      repeat (20) cycle(0, 0, '0);
      check("bp_reqs", reqs, D);
      check("bp_buffered_pc", bus.instr_pc, 16'h0000);
      repeat (10) cycle(1, 0, '0);

      // redirect while the fetch of 0x0008 is outstanding
      do_reset();
      for (int i = 0; i < 40 && !(pend && pend_addr == 16'h0008); i++) cycle(1, 0, '0);
      check("redir_setup", pend && pend_addr == 16'h0008, 1);
      cnt = 3;
      cycle(1, 1, 16'h0040);
      r0 = reqs;
      for (int i = 0; i < 12 && reqs == r0; i++) cycle(1, 0, '0);
      check("redir_next_addr", last_req, 16'h0040);
      repeat (6) cycle(1, 0, '0);

      // redirect coincident with the response and a pop
      for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, '0);
      cnt = 1;
      cycle(1, 1, 16'h0100);
      r0 = reqs;
      for (int i = 0; i < 12 && reqs == r0; i++) cycle(1, 0, '0);
      check("coinc_next_addr", last_req, 16'h0100);

      // random latency, backpressure and redirects
      lat_max = 5;
      pops = 0;
      repeat (800) cycle($urandom % 2 == 0, $urandom % 20 == 0, PW'($urandom) & 16'hFFFC);
      check("random_progress", pops > 40, 1);

      // asynchronous reset between edges while a fetch is outstanding
      for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, '0);
      check("arst_setup", pend, 1);
      @(negedge clk);
      #2 rst = 1;
      bus.PC = '0;
      #1;
      check("arst_mem_req", bus.mem_req, 0);
      check("arst_pc_adv", bus.pc_adv, 0);
      check("arst_instr_valid", bus.instr_valid, 0);
      check("arst_mem_addr", bus.mem_addr, 0);
      check("arst_instr", bus.instr, 0);
      check("arst_instr_pc", bus.instr_pc, 0);
      rst = 0;
      bus.mem_valid = 1;
      bus.mem_rdata = 32'hDEADBEEF;
      #1 check("stray_pc_adv", bus.pc_adv, 0);
      q.delete(); pend = 0; stale = 0; pc_reg = '0;
      repeat (4) cycle(1, 0, '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
